// File: rtl/burst_data_freezer.sv
// burst_data_freezer
//   Bridges a slow target-domain master, which advances on io_tick, to a fast memory port
//   running on the same clock. The bridge issues at most one read and one write per target
//   cycle. It holds io_in_wait_n until the next tick and buffers returned read words in a
//   small FIFO. It presents those words one per target cycle, so the slow master never misses
//   a beat of a burst.
//
// Parameters
//   ADDR_WIDTH  address width, passed through unchanged
//   DATA_WIDTH  data width of the read/write words
//   BURST_LEN   words returned per accepted read (1..DEPTH)
//   DEPTH       read FIFO entries, power of two, >= BURST_LEN
//
// Ports
//   clock, reset                  fast clock, asynchronous active-high reset
//   io_tick                       one-cycle pulse at the start of each target cycle
//   io_in_rd/wr/addr/din          master request side
//   io_in_dout/valid              word presented to the master for the current target cycle
//   io_in_wait_n                  request accepted, held until the next tick
//   io_out_rd/wr/addr/din         memory request side
//   io_out_dout/valid/wait_n      memory response and acceptance
//   io_overflow                   sticky flag: a returned word was dropped on a full FIFO
module burst_data_freezer #(
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned BURST_LEN  = 1,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  io_tick,
  input  logic                  io_in_rd,
  input  logic                  io_in_wr,
  input  logic [ADDR_WIDTH-1:0] io_in_addr,
  input  logic [DATA_WIDTH-1:0] io_in_din,
  output logic [DATA_WIDTH-1:0] io_in_dout,
  output logic                  io_in_wait_n,
  output logic                  io_in_valid,
  output logic                  io_out_rd,
  output logic                  io_out_wr,
  output logic [ADDR_WIDTH-1:0] io_out_addr,
  output logic [DATA_WIDTH-1:0] io_out_din,
  input  logic [DATA_WIDTH-1:0] io_out_dout,
  input  logic                  io_out_wait_n,
  input  logic                  io_out_valid,
  output logic                  io_overflow
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);
  localparam logic [CntW-1:0] BurstCnt = CntW'(BURST_LEN);
  localparam logic [PtrW-1:0] LastPtr  = PtrW'(DEPTH - 1);

  // Read FIFO storage and bookkeeping
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic [CntW-1:0]       free_slots;
  logic                  fifo_empty, fifo_full;
  logic                  push, pop, drop;

  // Request tracking
  logic [CntW-1:0]       inflight_q, inflight_d;
  logic                  rd_pend_q, rd_pend_d;
  logic                  wr_pend_q, wr_pend_d;
  logic                  wait_hold_q, wait_hold_d;
  logic                  rd_accept, wr_accept;

  // Presentation register
  logic                  pres_valid_q, pres_valid_d;
  logic [DATA_WIDTH-1:0] pres_data_q, pres_data_d;
  logic                  overflow_q, overflow_d;

  // Request side
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == DepthCnt);
  assign free_slots = DepthCnt - count_q;

  // A read is only issued when the previous burst has fully returned and the whole
  // next burst is guaranteed to fit, so a well-behaved memory can never overflow us.
  assign io_out_rd = io_in_rd & ~rd_pend_q & (inflight_q == '0) & (free_slots >= BurstCnt);
  assign io_out_wr = io_in_wr & ~wr_pend_q;

  assign rd_accept = io_out_rd & io_out_wait_n;
  assign wr_accept = io_out_wr & io_out_wait_n;

  assign io_out_addr  = io_in_addr;
  assign io_out_din   = io_in_din;
  assign io_in_wait_n = io_out_wait_n | wait_hold_q;

  // Return path: a pop on the same tick frees the slot for an incoming word
  assign pop  = io_tick & ~fifo_empty;
  assign push = io_out_valid & (~fifo_full | pop);
  assign drop = io_out_valid & fifo_full & ~pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (push) begin
      wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrW'(1);
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    inflight_d = inflight_q;
    if (rd_accept) begin
      inflight_d = BurstCnt;
    end else if (io_out_valid && (inflight_q != '0)) begin
      // Unsolicited words do not push the counter below zero
      inflight_d = inflight_q - CntW'(1);
    end
  end

  // Pending flags and wait hold clear on a tick, but a same-cycle accept wins so a request
  // accepted on the tick still counts as this target cycle's single issue.
  always_comb begin
    rd_pend_d   = rd_accept | (rd_pend_q & ~io_tick);
    wr_pend_d   = wr_accept | (wr_pend_q & ~io_tick);
    wait_hold_d = rd_accept | wr_accept | (wait_hold_q & ~io_tick);
    overflow_d  = overflow_q | drop;
  end

  // Presentation: each tick re-decides validity; data holds when nothing is popped
  always_comb begin
    pres_valid_d = pres_valid_q;
    pres_data_d  = pres_data_q;
    if (io_tick) begin
      pres_valid_d = ~fifo_empty;
    end
    if (pop) begin
      pres_data_d = mem_q[rd_ptr_q];
    end
  end

  assign io_in_valid = pres_valid_q;
  assign io_in_dout  = pres_data_q;
  assign io_overflow = overflow_q;

  // Storage needs no reset: emptiness is tracked by the count
  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= io_out_dout;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      inflight_q   <= '0;
      rd_pend_q    <= 1'b0;
      wr_pend_q    <= 1'b0;
      wait_hold_q  <= 1'b0;
      pres_valid_q <= 1'b0;
      pres_data_q  <= '0;
      overflow_q   <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      inflight_q   <= inflight_d;
      rd_pend_q    <= rd_pend_d;
      wr_pend_q    <= wr_pend_d;
      wait_hold_q  <= wait_hold_d;
      pres_valid_q <= pres_valid_d;
      pres_data_q  <= pres_data_d;
      overflow_q   <= overflow_d;
    end
  end

endmodule
